adder_accumulator: RTL and testbench

ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

---
 rtl/adder_pkg.sv | 13 +
 rtl/fullAdder4.sv | 23 ++
 rtl/adder_accumulator.sv | 113 +++++++++++
 tb/tb_adder_accumulator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared state encoding and default widths for the adder accumulator.
package adder_pkg;

  localparam int N_DEF     = 5;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fullAdder4.sv
// Parameterized ripple-carry adder: Sum = A + B + Cin, Cout is the carry out of the top bit.
module fullAdder4 #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic [N:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry[N];

endmodule

// File: rtl/adder_accumulator.sv
// Streaming accumulator: sums beats up to in_last, then holds the result until accepted downstream.
// Optional macro ADDER_ACCUMULATOR_SAT_EN makes the sum saturate at 2^N-1 instead of wrapping.
module adder_accumulator
  import adder_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_cout,
  output logic [CNT_W-1:0] out_count
);

  // state | meaning
  // IDLE  | no sum in progress; next beat starts a new sum
  // ACC   | sum in progress; beats are added to acc
  // HOLD  | result presented; waiting for out_ready
  state_t state, state_nxt;

  logic [N-1:0]     acc;
  logic             cout;
  logic [CNT_W-1:0] count;

  logic [N-1:0]     add_sum;
  logic             add_carry;
  logic [N-1:0]     acc_nxt;
  logic             accept;

  fullAdder4 #(.N(N)) u_add (
    .A    (acc),
    .B    (in_data),
    .Cin  (1'b0),
    .Sum  (add_sum),
    .Cout (add_carry)
  );

`ifdef ADDER_ACCUMULATOR_SAT_EN
  // Once any carry has occurred in this sum the result is pinned at full scale.
  assign acc_nxt = (cout | add_carry) ? {N{1'b1}} : add_sum;
`else
  assign acc_nxt = add_sum;
`endif

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cout  <= 1'b0;
      count <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc   <= in_data;
        cout  <= 1'b0;
        count <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        acc  <= acc_nxt;
        cout <= cout | add_carry;
        if (count != {CNT_W{1'b1}}) begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign out_sum   = acc;
  assign out_cout  = cout;
  assign out_count = count;

endmodule

// File: tb/tb_adder_accumulator.sv
// Randomized and directed bench for adder_accumulator against an arithmetic reference model.
module tb_adder_accumulator;

  localparam int N     = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic             out_cout;
  logic [CNT_W-1:0] out_count;

  int errors = 0;
  int checks = 0;
  int beats[$];

  always #5 clk = ~clk;

  adder_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_count (out_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic over the beat list.
  task automatic model(output int s, output int c, output int n);
    int t;
    s = beats[0];
    c = 0;
    for (int i = 1; i < beats.size(); i++) begin
      t = s + beats[i];
      if (t >= (1 << N)) c = 1;
      s = t % (1 << N);
`ifdef ADDER_ACCUMULATOR_SAT_EN
      if (c == 1) s = (1 << N) - 1;
`endif
    end
    n = (beats.size() > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : beats.size();
  endtask

  // Negative expectation values mean "take it from the model".
  task automatic run_sum(input int stall, input bit gaps, input int xs, input int xc, input int xn);
    int es, ec, en;
    model(es, ec, en);
    if (xs >= 0) es = xs;
    if (xc >= 0) ec = xc;
    if (xn >= 0) en = xn;
    foreach (beats[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = N'($urandom);
        in_last   = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(negedge clk);
      chk("in_ready_open", 32'(in_ready), 1);
      chk("out_valid_low", 32'(out_valid), 0);
      in_valid  = 1'b1;
      in_data   = N'(beats[i]);
      in_last   = (i == beats.size() - 1);
      out_ready = 1'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = N'($urandom);
    out_ready = 1'b0;
    chk("out_valid", 32'(out_valid), 1);
    chk("out_sum", 32'(out_sum), es);
    chk("out_cout", 32'(out_cout), ec);
    chk("out_count", 32'(out_count), en);
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      in_data  = N'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_sum", 32'(out_sum), es);
      chk("hold_cout", 32'(out_cout), ec);
      chk("hold_count", 32'(out_count), en);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(out_valid), 0);
    chk("release_in_ready", 32'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int len;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_sum", 32'(out_sum), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_cout", 32'(out_cout), 0);
    rst_n = 1'b1;

    beats = '{7, 11};
    run_sum(0, 0, 18, 0, 2);

    beats = '{15, 27};
`ifdef ADDER_ACCUMULATOR_SAT_EN
    run_sum(0, 0, 31, 1, 2);
`else
    run_sum(0, 0, 10, 1, 2);
`endif

    beats = '{9};
    run_sum(0, 0, 9, 0, 1);

    beats = '{4, 6, 8};
    run_sum(3, 0, 18, 0, 3);

    beats.delete();
    for (int i = 0; i < 16; i++) beats.push_back(1);
    run_sum(0, 0, 16, 0, 15);

    // Mid-sum reset discards the partial result.
    @(negedge clk);
    in_valid = 1'b1; in_data = 5'd3; in_last = 1'b0;
    @(negedge clk);
    in_data = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_count", 32'(out_count), 0);
    chk("midrst_sum", 32'(out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_valid", 32'(out_valid), 0);
    beats = '{5, 6};
    run_sum(0, 0, 11, 0, 2);

    for (int t = 0; t < 40; t++) begin
      beats.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) beats.push_back($urandom_range(0, (1 << N) - 1));
      run_sum($urandom_range(0, 3), 1, -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
